// File: rtl/pim_desc_scheduler.sv
// pim_desc_scheduler: walks a linked descriptor chain, dispatches one PIM op per descriptor
// and writes a status word back into each descriptor after its op completes.
module pim_desc_scheduler #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int IDXW = 8
) (
    input  logic            clk,
    input  logic            rst_x,
    input  logic            start,
    input  logic [31:0]     first_desc_addr,
    input  logic [IDXW-1:0] desc_count,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            req_valid,
    input  logic            req_ready,
    output logic            req_write,
    output logic [31:0]     req_addr,
    output logic [31:0]     req_wdata,
    input  logic            rd_data_valid,
    input  logic [255:0]    rd_data,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [7:0]      op_code,
    output logic [31:0]     op_src_addr,
    output logic [31:0]     op_dst_addr,
    output logic [15:0]     op_len_beats,
    input  logic            op_done
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [2:0] {IDLE, FETCH_REQ, FETCH_WAIT, DISPATCH, EXEC, WB_REQ, FINISH} state_t;
    state_t          state, state_n;
    logic [31:0]     cur_addr, cur_addr_n, nxt_addr, nxt_addr_n;
    logic [IDXW-1:0] idx, idx_n, lim, lim_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            err_n;
    logic [7:0]      code_n;
    logic [31:0]     src_n, dst_n;
    logic [15:0]     len_n;
    logic [31:0]     w6;
    logic            bad;
    assign w6  = rd_data[223:192];
    assign bad = (w6[4:0] != 5'd0) || (w6 == 32'd0) || (w6[31:21] != 11'd0);
    always_comb begin
        state_n    = state;
        cur_addr_n = cur_addr;
        nxt_addr_n = nxt_addr;
        idx_n      = idx;
        lim_n      = lim;
        cnt_n      = cnt;
        err_n      = err;
        code_n     = op_code;
        src_n      = op_src_addr;
        dst_n      = op_dst_addr;
        len_n      = op_len_beats;
        case (state)
            IDLE: if (start) begin
                err_n      = 1'b0;
                cur_addr_n = first_desc_addr;
                idx_n      = '0;
                lim_n      = desc_count;
                state_n    = (desc_count != '0) ? FETCH_REQ : FINISH;
            end
            FETCH_REQ: if (req_ready) begin
                cnt_n   = '0;
                state_n = FETCH_WAIT;
            end
            FETCH_WAIT: if (rd_data_valid) begin
                nxt_addr_n = rd_data[31:0];
                src_n      = rd_data[95:64];
                dst_n      = rd_data[159:128];
                len_n      = w6[20:5];
                code_n     = rd_data[231:224];
                err_n      = bad;
                state_n    = bad ? FINISH : DISPATCH;
            end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                err_n   = 1'b1;
                state_n = FINISH;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            DISPATCH: if (op_ready) state_n = EXEC;
            EXEC: if (op_done) state_n = WB_REQ;
            WB_REQ: if (req_ready) begin
                idx_n      = idx + 1'b1;
                cur_addr_n = nxt_addr;
                state_n    = (idx_n == lim) ? FINISH : FETCH_REQ;
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Outputs are registered from next-state values so they line up with the state they belong to
    always_ff @(posedge clk or posedge rst_x) begin
        if (rst_x) begin
            state        <= IDLE;
            cur_addr     <= '0;
            nxt_addr     <= '0;
            idx          <= '0;
            lim          <= '0;
            cnt          <= '0;
            err          <= 1'b0;
            op_code      <= '0;
            op_src_addr  <= '0;
            op_dst_addr  <= '0;
            op_len_beats <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            req_valid    <= 1'b0;
            req_write    <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            op_valid     <= 1'b0;
        end else begin
            state        <= state_n;
            cur_addr     <= cur_addr_n;
            nxt_addr     <= nxt_addr_n;
            idx          <= idx_n;
            lim          <= lim_n;
            cnt          <= cnt_n;
            err          <= err_n;
            op_code      <= code_n;
            op_src_addr  <= src_n;
            op_dst_addr  <= dst_n;
            op_len_beats <= len_n;
            busy         <= state_n != IDLE;
            done         <= state == FINISH;
            req_valid    <= (state_n == FETCH_REQ) || (state_n == WB_REQ);
            req_write    <= state_n == WB_REQ;
            req_addr     <= (state_n == WB_REQ) ? cur_addr_n + 32'h1C : cur_addr_n;
            req_wdata    <= (state_n == WB_REQ) ? {16'h0, 8'(idx_n), 8'h01} : '0;
            op_valid     <= state_n == DISPATCH;
        end
    end
endmodule

// File: tb/tb_pim_desc_scheduler.sv
// tb_pim_desc_scheduler: directed chains checked against a chain-walking reference model.
module tb_pim_desc_scheduler;
    logic         clk = 1'b0, rst_x = 1'b1, start = 1'b0;
    logic [31:0]  first_desc_addr = '0;
    logic [7:0]   desc_count = '0;
    logic         busy, done, err, req_valid, req_write, op_valid;
    logic         req_ready = 1'b1, op_ready = 1'b1, rd_data_valid = 1'b0, op_done = 1'b0;
    logic [31:0]  req_addr, req_wdata, op_src_addr, op_dst_addr;
    logic [255:0] rd_data = '0;
    logic [7:0]   op_code;
    logic [15:0]  op_len_beats;

    pim_desc_scheduler dut (
        .clk(clk), .rst_x(rst_x), .start(start), .first_desc_addr(first_desc_addr),
        .desc_count(desc_count), .busy(busy), .done(done), .err(err),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rd_data_valid(rd_data_valid),
        .rd_data(rd_data), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_src_addr(op_src_addr), .op_dst_addr(op_dst_addr), .op_len_beats(op_len_beats),
        .op_done(op_done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, ndone = 0;
    logic [255:0] mem [logic [31:0]];
    logic [64:0]  exp_req[$];
    logic [87:0]  exp_op[$];
    bit exp_err = 0, mem_en = 1, dup = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [255:0] mk(input logic [31:0] nxt, src, dst, len, input logic [7:0] code);
        return {24'hABCDEF, code, len, 32'h5555_5555, dst, 32'hAAAA_AAAA, src, 32'hDEAD_BEEF, nxt};
    endfunction

    // Walks the chain in memory exactly as the host-side contract describes it
    task automatic model(input logic [31:0] first, input int count, input bit nodata);
        logic [31:0]  a, l;
        logic [255:0] d;
        exp_req.delete();
        exp_op.delete();
        exp_err = 0;
        a = first;
        for (int i = 0; i < count; i++) begin
            exp_req.push_back({1'b0, a, 32'h0});
            if (nodata) begin exp_err = 1; break; end
            d = mem.exists(a) ? mem[a] : '0;
            l = d[223:192];
            if (l % 32 != 0 || l == 0 || l >= 32'h0020_0000) begin exp_err = 1; break; end
            exp_op.push_back({d[231:224], d[95:64], d[159:128], 16'(l / 32)});
            exp_req.push_back({1'b1, a + 32'h1C, 32'((i % 256) * 256 + 1)});
            a = d[31:0];
        end
    endtask

    task automatic go(input logic [31:0] first, input logic [7:0] count);
        @(posedge clk) #1;
        first_desc_addr = first;
        desc_count = count;
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (ndone == 0 && t < 3000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        chk({nm, "_ndone"}, ndone, 1);
        chk({nm, "_reqs_left"}, exp_req.size(), 0);
        chk({nm, "_ops_left"}, exp_op.size(), 0);
        chk({nm, "_err"}, err, exp_err);
        ndone = 0;
    endtask

    task automatic run(input logic [31:0] first, input logic [7:0] count, input string nm);
        model(first, count, 0);
        go(first, count);
        wait_done(nm);
    endtask

    task automatic wait_hi(input bit is_op, input string nm);
        int t = 0;
        @(negedge clk);
        while (!(is_op ? op_valid : req_valid) && t < 100) begin @(negedge clk); t++; end
        chk(nm, t < 100, 1);
    endtask

    // Compare process: every transfer against the model, plus valid/payload hold while stalled
    initial begin
        logic pv = 0, pr = 0, pov = 0, por = 0;
        logic [64:0] pp, cur;
        logic [87:0] pop, curo;
        forever begin
            @(negedge clk);
            if (rst_x) begin
                pv = 0;
                pov = 0;
            end else begin
                cur  = {req_write, req_addr, req_write ? req_wdata : 32'h0};
                curo = {op_code, op_src_addr, op_dst_addr, op_len_beats};
                if (pv && !pr) chk("req_hold", {req_valid, cur}, {1'b1, pp});
                if (pov && !por) chk("op_hold", {op_valid, curo}, {1'b1, pop});
                if (req_valid && req_ready) begin
                    if (exp_req.size() == 0) chk("req_unexpected", {1'b1, cur}, 0);
                    else chk("req", cur, exp_req.pop_front());
                end
                if (op_valid && op_ready) begin
                    if (exp_op.size() == 0) chk("op_unexpected", {1'b1, curo}, 0);
                    else chk("op", curo, exp_op.pop_front());
                end
                if (done) begin
                    ndone++;
                    chk("done_err", err, exp_err);
                end
                pv = req_valid; pr = req_ready; pp = cur;
                pov = op_valid; por = op_ready; pop = curo;
            end
        end
    end

    // Memory: answers each descriptor read two cycles later, optionally followed by a junk beat
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (!rst_x && req_valid && req_ready && !req_write && mem_en) begin
                a = req_addr;
                repeat (2) @(negedge clk);
                rd_data = mem.exists(a) ? mem[a] : '0;
                rd_data_valid = 1'b1;
                @(negedge clk);
                if (dup) begin rd_data = '1; @(negedge clk); end
                rd_data_valid = 1'b0;
                rd_data = '0;
            end
        end
    end

    // Engine: completes each accepted op three cycles later
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_x && op_valid && op_ready) begin
                repeat (3) @(negedge clk);
                op_done = 1'b1;
                @(negedge clk);
                op_done = 1'b0;
            end
        end
    end

    initial begin
        int t;
        mem[32'h0080_0000] = mk(32'h0080_0040, 32'h0100_0000, 32'hD000_0000, 32'h20, 8'hF2);
        mem[32'h0080_0040] = mk(32'h0080_0080, 32'h0100_2000, 32'hD000_0000, 32'h2000, 8'hF4);
        mem[32'h0080_0080] = mk(32'h0080_00C0, 32'hD000_0000, 32'h0100_4000, 32'h20, 8'hF9);
        mem[32'h0000_1000] = mk(32'h0000_2000, 32'h1, 32'h2, 32'h21, 8'h11);
        mem[32'h0000_2000] = mk(32'h0, 32'h1234_0000, 32'h5678_0000, 32'h40, 8'h33);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, err, req_valid, req_write, req_addr, req_wdata, op_valid,
                              op_code, op_src_addr, op_dst_addr, op_len_beats}, 0);
        @(posedge clk) #1 rst_x = 1'b0;

        model(32'h0080_0000, 3, 0);
        chk("model_nreq", exp_req.size(), 6);
        chk("model_wb0", exp_req[1], {1'b1, 32'h0080_001C, 32'h1});
        chk("model_wb2", exp_req[5], {1'b1, 32'h0080_009C, 32'h201});
        chk("model_op1", exp_op[1], {8'hF4, 32'h0100_2000, 32'hD000_0000, 16'd256});
        dup = 1;
        go(32'h0080_0000, 3);
        wait_done("chain3");
        dup = 0;

        model(32'h0, 0, 0);
        go(32'h0, 0);
        @(negedge clk);
        chk("zero_cycle1", {busy, done}, 2'b10);
        @(negedge clk);
        chk("zero_cycle2", {busy, done}, 2'b01);
        wait_done("zero");

        run(32'h0000_1000, 2, "badlen");
        chk("badlen_err_lit", err, 1);

        mem_en = 0;
        model(32'h0000_4000, 1, 1);
        go(32'h0000_4000, 1);
        wait_hi(0, "timeout_req");
        t = 0;
        while (!done && t < 1200) begin @(negedge clk); t++; end
        chk("timeout_cycles", (t >= 1024 && t <= 1026), 1);
        wait_done("timeout");
        chk("timeout_err_lit", err, 1);
        mem_en = 1;

        req_ready = 1'b0;
        op_ready = 1'b0;
        model(32'h0000_2000, 1, 0);
        go(32'h0000_2000, 1);
        wait_hi(0, "stall_req");
        @(posedge clk) #1;
        first_desc_addr = 32'h0000_3000;
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        first_desc_addr = 32'h0000_2000;
        repeat (3) @(posedge clk);
        #1 req_ready = 1'b1;
        wait_hi(1, "stall_op");
        chk("stall_op_lit", {op_code, op_src_addr, op_dst_addr, op_len_beats},
            {8'h33, 32'h1234_0000, 32'h5678_0000, 16'd2});
        repeat (5) @(posedge clk);
        #1 op_ready = 1'b1;
        wait_done("stall");

        model(32'h0080_0000, 3, 0);
        go(32'h0080_0000, 3);
        wait_hi(1, "rst_exec_op");
        @(posedge clk) #1 rst_x = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {busy, done, err, req_valid, req_write, req_addr, req_wdata, op_valid,
                            op_code, op_src_addr, op_dst_addr, op_len_beats}, 0);
        exp_req.delete();
        exp_op.delete();
        @(posedge clk) #1 rst_x = 1'b0;
        repeat (20) @(posedge clk);
        chk("rst_no_done", ndone, 0);
        run(32'h0080_0000, 3, "rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pim_desc_scheduler.md
# pim_desc_scheduler

Descriptor-chain scheduler for the indirect-addressing PIM device. After a start pulse it walks a linked list of 256-bit descriptors in the descriptor region and dispatches one operation per descriptor to the PIM execution engine. After each operation completes it writes a status word back into the descriptor. It sits between the host-visible start/config registers and the shared memory request port, and sequences the PIM datapath.

## Interface
- `TIMEOUT_CYC`, 1024: max cycles waiting for descriptor read data before error.
- `IDXW`, 8: width of descriptor count/index.
- `clk` in 1: the single clock; all logic on rising edge.
- `rst_x` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle chain start pulse.
- `first_desc_addr` in 32: address of first descriptor (32-byte aligned).
- `desc_count` in IDXW: number of descriptors to execute.
- `busy` out 1: chain in progress.
- `done` out 1: one-cycle pulse at chain end (normal or error).
- `err` out 1: sticky error flag; cleared by next accepted `start`.
- `req_valid` out 1: memory request valid.
- `req_ready` in 1: memory request accepted.
- `req_write` out 1: 1 = status write, 0 = descriptor read.
- `req_addr` out 32: request address.
- `req_wdata` out 32: status word for writes.
- `rd_data_valid` in 1: read data beat valid.
- `rd_data` in 256: read data beat.
- `op_valid` out 1: operation dispatch valid.
- `op_ready` in 1: engine accepts operation.
- `op_code` out 8, `op_src_addr` out 32, `op_dst_addr` out 32, `op_len_beats` out 16: operation fields.
- `op_done` in 1: engine finished current operation (pulse).

## Operation
- Descriptor words w0..w7 are 32-bit, with w0 = `rd_data[31:0]`.
  - w0: next descriptor address.
  - w2: source address.
  - w4: destination address.
  - w6: length in bytes.
  - w7[7:0]: opcode.
  - w1, w3, w5 and w7[31:8] are ignored.
- `op_len_beats` = w6[20:5].
- Error conditions: w6[4:0] != 0, w6 == 0, or w6[31:21] != 0.
- FSM states: IDLE, FETCH_REQ, FETCH_WAIT, DISPATCH, EXEC, WB_REQ, FINISH.
- IDLE:
  - `start` with `desc_count` != 0: clear `err`, load cur_addr = `first_desc_addr`, idx = 0, go to FETCH_REQ.
  - `start` with `desc_count` == 0: go to FINISH with no requests.
- FETCH_REQ: `req_valid`=1, `req_write`=0, `req_addr` = cur_addr. On `req_ready`, go to FETCH_WAIT and clear the timeout counter.
- FETCH_WAIT:
  - The first `rd_data_valid` beat latches the descriptor.
  - Illegal length: set `err`, go to FINISH.
  - Otherwise go to DISPATCH.
  - Counter reaches `TIMEOUT_CYC`: set `err`, go to FINISH.
- DISPATCH: `op_valid`=1 with the latched fields. On `op_ready`, go to EXEC.
- EXEC: wait for `op_done`, then go to WB_REQ.
- WB_REQ:
  - `req_valid`=1, `req_write`=1, `req_addr` = cur_addr + 0x1C, `req_wdata` = {16'h0, idx[7:0], 8'h01}.
  - On `req_ready`, idx increments.
  - If idx+1 == `desc_count`, go to FINISH.
  - Otherwise cur_addr = w0 and go to FETCH_REQ.
- FINISH: `done`=1 for one cycle, then IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; cur_addr, idx, latched descriptor and counter all 0.
- All outputs are registered.
- Latencies:
  - `start` to first `req_valid`: 1 cycle.
  - Data beat to `op_valid`: 1 cycle.
  - `op_done` to write `req_valid`: 1 cycle.
- Valid/ready rules:
  - `req_valid` and `op_valid` plus their payloads stay stable until the ready is sampled high.
  - Transfer occurs on the edge where both are 1.
  - Ready may be high before valid.
- `start` while `busy`: ignored.
- `rd_data_valid` outside FETCH_WAIT, and extra beats after the first: ignored.
- `op_done` outside EXEC: ignored.
- `op_done` in the same cycle as `op_ready`: not possible per engine contract; EXEC samples only from the next cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32. idx wraps at 2^IDXW, so the maximum chain is 2^IDXW−1.
- `rst_x` mid-chain: immediate return to IDLE with all outputs 0; no `done` pulse and no partial write.

## Test plan
- start, first_desc_addr=0x0080_0000, desc_count=3; descriptors 0x…0080_0040/…0080_0080/…0080_00C0 chain (lengths 0x20/0x2000/0x20). Required:
  - Reads at 0x0080_0000, 0x0080_0040, 0x0080_0080.
  - Ops (F2, src 0x0100_0000, dst 0xD000_0000, 1 beat), (F4, 0x0100_2000, 0xD000_0000, 256), (F9, 0xD000_0000, 0x0100_4000, 1).
  - Writes to 0x0080_001C/005C/009C with wdata 0x01/0x101/0x201.
  - One `done` pulse, `err`=0.
- desc_count=0 -> `done` pulse 2 cycles after start, no `req_valid`, `busy` high for 1 cycle.
- Descriptor with w6=0x21 -> `err`=1, `done` pulse, no `op_valid`, no write-back.
- No read data returned -> after 1024 cycles `err`=1 and `done`.
- `req_ready`/`op_ready` held low 5 cycles -> valid and payload stable throughout; second `start` during `busy` ignored.
- Assert `rst_x` during EXEC -> all outputs 0 next cycle; a later start runs the full chain correctly.
